// File: rtl/result_writer.sv
// Store path from the divider into result RAM: each finished rise is captured
// and written as a record via a ready/ack port. Define OPERAND_STORE_EN to
// append dividend and divisor to every record (4 words instead of 2).
module result_writer #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 9,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              finished,
   input  logic [7:0]        quotient,
   input  logic [8:0]        remainder,
   input  logic [7:0]        dividend,
   input  logic [7:0]        divisor,
   input  logic              clr_ovf,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ack,
   output logic              busy,
   output logic              rec_done,
   output logic [7:0]        rec_count,
   output logic              overflow
);

   // state   | meaning
   // IDLE    | waiting for a finished rise
   // WR0     | writing quotient
   // WR1     | writing remainder
   // WR2     | writing dividend (OPERAND_STORE_EN only)
   // WR3     | writing divisor  (OPERAND_STORE_EN only)
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WR0  = 3'd1;
   localparam logic [2:0] ST_WR1  = 3'd2;
`ifdef OPERAND_STORE_EN
   localparam logic [2:0] ST_WR2  = 3'd3;
   localparam logic [2:0] ST_WR3  = 3'd4;
   localparam logic [2:0] ST_LAST = ST_WR3;
`else
   localparam logic [2:0] ST_LAST = ST_WR1;
`endif

   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

   logic [2:0]        state;
   logic [2:0]        state_next;
   logic              finished_d;
   logic [ADDR_W-1:0] ptr;
   logic [7:0]        q_lat;
   logic [8:0]        r_lat;
   logic              rise;
   logic              start;
   logic              drop;
   logic              accept;
   logic              rec_last;

   assign rise     = finished & ~finished_d;
   assign busy     = (state != ST_IDLE);
   assign start    = rise & ~busy;
   assign drop     = rise & busy;
   assign wr_en    = busy;
   assign accept   = wr_en & wr_ack;
   assign rec_last = accept & (state == ST_LAST);
   assign wr_addr  = BASE + ptr;

   always_comb begin
      state_next = state;
      if (state == ST_IDLE) begin
         if (rise) state_next = ST_WR0;
      end else if (accept) begin
         state_next = (state == ST_LAST) ? ST_IDLE : state + 3'd1;
      end
   end

`ifdef OPERAND_STORE_EN
   logic [7:0] a_lat;
   logic [7:0] b_lat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_lat <= '0;
         b_lat <= '0;
      end else if (start) begin
         a_lat <= dividend;
         b_lat <= divisor;
      end
   end
`else
   logic unused_operands;
   assign unused_operands = ^{dividend, divisor};
`endif

   always_comb begin
      wr_data = '0;
      case (state)
         ST_WR0:  wr_data = DATA_W'(q_lat);
         ST_WR1:  wr_data = DATA_W'(r_lat);
`ifdef OPERAND_STORE_EN
         ST_WR2:  wr_data = DATA_W'(a_lat);
         ST_WR3:  wr_data = DATA_W'(b_lat);
`endif
         default: wr_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         finished_d <= 1'b0;
         ptr        <= '0;
         q_lat      <= '0;
         r_lat      <= '0;
         rec_done   <= 1'b0;
         rec_count  <= '0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_next;
         finished_d <= finished;
         rec_done   <= rec_last;
         if (rec_last) rec_count <= rec_count + 8'd1;
         // each word wraps on its own, so a record may straddle the region end
         if (accept) ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
         if (start) begin
            q_lat <= quotient;
            r_lat <= remainder;
         end
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_result_writer.sv
// Bench for result_writer: table of records through a write scoreboard plus
// hand sequences for latency, overflow, wrap and reset mid-record.
module tb_result_writer;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 9;
   localparam int BASE   = 0;
   localparam int DEPTH  = 7;

   logic              clk;
   logic              rst;
   logic              finished;
   logic [7:0]        quotient;
   logic [8:0]        remainder;
   logic [7:0]        dividend;
   logic [7:0]        divisor;
   logic              clr_ovf;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              busy;
   logic              rec_done;
   logic [7:0]        rec_count;
   logic              overflow;

   result_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .finished(finished), .quotient(quotient),
      .remainder(remainder), .dividend(dividend), .divisor(divisor),
      .clr_ovf(clr_ovf), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .busy(busy), .rec_done(rec_done),
      .rec_count(rec_count), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]        q;
      logic [8:0]        r;
      logic [7:0]        a;
      logic [7:0]        b;
      int                stall0;
      int                stall1;
      logic [DATA_W-1:0] w0;
      logic [DATA_W-1:0] w1;
      logic [DATA_W-1:0] w2;
      logic [DATA_W-1:0] w3;
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } exp_t;

   int   total = 0;
   int   bad = 0;
   int   ptr_m = 0;
   int   count_m = 0;
   exp_t exp_q[$];
   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d);
      exp_t e;
      e.addr = ADDR_W'(BASE + ptr_m);
      e.data = d;
      exp_q.push_back(e);
      ptr_m = (ptr_m == DEPTH - 1) ? 0 : ptr_m + 1;
   endtask

   task automatic push_rec(input vec_t v);
      push_word(v.w0);
      push_word(v.w1);
`ifdef OPERAND_STORE_EN
      push_word(v.w2);
      push_word(v.w3);
`endif
   endtask

   task automatic drive_rec(input vec_t v);
      quotient  = v.q;
      remainder = v.r;
      dividend  = v.a;
      divisor   = v.b;
   endtask

   task automatic run_rec(input vec_t v);
      int  stall;
      int  w;
      bit  done;
      push_rec(v);
      @(posedge clk); #1;
      drive_rec(v);
      finished = 1'b1;
      wr_ack   = 1'b1;
      stall    = v.stall0;
      w        = 0;
      done     = 1'b0;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 0) finished = 1'b0;
         if (rec_done) done = 1'b1;
         else if (wr_en) begin
            if (stall > 0) begin
               wr_ack = 1'b0;
               stall--;
            end else begin
               wr_ack = 1'b1;
               w++;
               stall = (w == 1) ? v.stall1 : 0;
            end
         end else wr_ack = 1'($urandom_range(0, 1));
      end
      chk("rec_done_seen", int'(done), 1);
      count_m++;
      chk("rec_count", int'(rec_count), count_m % 256);
      chk("busy_after_rec", int'(busy), 0);
      wr_ack = 1'b1;
      @(posedge clk); #1;
      chk("rec_done_one_cycle", int'(rec_done), 0);
   endtask

   // write scoreboard and hold-stability monitor
   bit                stall_prev = 1'b0;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_data;
   always @(negedge clk) begin
      if (!rst) stall_prev = 1'b0;
      else begin
         if (stall_prev && wr_en) begin
            chk("hold_addr", int'(wr_addr), int'(hold_addr));
            chk("hold_data", int'(wr_data), int'(hold_data));
         end
         if (wr_en && wr_ack) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: addr %0d data %0d with no word pending",
                        wr_addr, wr_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("wr_addr", int'(wr_addr), int'(e.addr));
               chk("wr_data", int'(wr_data), int'(e.data));
            end
         end
         stall_prev = wr_en && !wr_ack;
         hold_addr  = wr_addr;
         hold_data  = wr_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t ov;
      vec_t rv;
      tbl[0] = '{q:8'd20,  r:9'd5,     a:8'd100, b:8'd5,  stall0:0, stall1:0,
                 w0:9'd20,  w1:9'd5,   w2:9'd100, w3:9'd5};
      tbl[1] = '{q:8'd255, r:9'd511,   a:8'd255, b:8'd1,  stall0:3, stall1:0,
                 w0:9'd255, w1:9'd511, w2:9'd255, w3:9'd1};
      tbl[2] = '{q:8'd0,   r:9'd0,     a:8'd0,   b:8'd9,  stall0:0, stall1:2,
                 w0:9'd0,   w1:9'd0,   w2:9'd0,   w3:9'd9};
      tbl[3] = '{q:8'h5A,  r:9'h1A5,   a:8'hC3,  b:8'h3C, stall0:1, stall1:1,
                 w0:9'd90,  w1:9'd421, w2:9'd195, w3:9'd60};
      tbl[4] = '{q:8'd1,   r:9'd256,   a:8'd128, b:8'd2,  stall0:0, stall1:0,
                 w0:9'd1,   w1:9'd256, w2:9'd128, w3:9'd2};
      tbl[5] = '{q:8'd7,   r:9'd1,     a:8'd50,  b:8'd7,  stall0:0, stall1:0,
                 w0:9'd7,   w1:9'd1,   w2:9'd50,  w3:9'd7};
      ov = '{q:8'd33, r:9'd44, a:8'd3, b:8'd4, stall0:0, stall1:0,
             w0:9'd33, w1:9'd44, w2:9'd3, w3:9'd4};
      rv = '{q:8'd11, r:9'd22, a:8'd13, b:8'd14, stall0:0, stall1:0,
             w0:9'd11, w1:9'd22, w2:9'd13, w3:9'd14};

      rst = 1'b0; finished = 1'b0; quotient = '0; remainder = '0;
      dividend = '0; divisor = '0; clr_ovf = 1'b0; wr_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rec_done", int'(rec_done), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_rec_count", int'(rec_count), 0);
      chk("rst_wr_addr", int'(wr_addr), BASE);
      chk("rst_wr_data", int'(wr_data), 0);
      rst = 1'b1;

      // basic record with ack tied high: one word per cycle
      @(posedge clk); #1;
      quotient = 8'd7; remainder = 9'd3; dividend = 8'd0; divisor = 8'd0;
      push_word(9'd7);
      push_word(9'd3);
`ifdef OPERAND_STORE_EN
      push_word(9'd0);
      push_word(9'd0);
`endif
      finished = 1'b1; wr_ack = 1'b1;
      @(posedge clk); #1;
      finished = 1'b0;
      chk("t1_wr_en", int'(wr_en), 1);
      chk("t1_busy", int'(busy), 1);
      chk("t1_addr0", int'(wr_addr), 0);
      chk("t1_data0", int'(wr_data), 7);
      @(posedge clk); #1;
      chk("t1_addr1", int'(wr_addr), 1);
      chk("t1_data1", int'(wr_data), 3);
`ifdef OPERAND_STORE_EN
      @(posedge clk); #1;
      chk("t1_addr2", int'(wr_addr), 2);
      @(posedge clk); #1;
      chk("t1_addr3", int'(wr_addr), 3);
`endif
      @(posedge clk); #1;
      chk("t1_rec_done", int'(rec_done), 1);
      chk("t1_rec_count", int'(rec_count), 1);
      chk("t1_idle", int'(busy), 0);
      count_m = 1;

      // table: stalls, extreme values, pointer wrap across the region end
      for (int i = 0; i < 6; i++) run_rec(tbl[i]);

      // overflow: rises while busy are dropped; set beats clear
      push_rec(ov);
      @(posedge clk); #1;
      drive_rec(ov); finished = 1'b1; wr_ack = 1'b0;
      @(posedge clk); #1;
      chk("ov_busy", int'(busy), 1);
      finished = 1'b0;
      @(posedge clk); #1;
      finished = 1'b1;
      @(posedge clk); #1;
      chk("ov_set", int'(overflow), 1);
      chk("ov_inflight_wr_en", int'(wr_en), 1);
      finished = 1'b0;
      @(posedge clk); #1;
      finished = 1'b1; clr_ovf = 1'b1;
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      chk("ov_set_wins", int'(overflow), 1);
      wr_ack = 1'b1;
      begin
         bit seen;
         seen = 1'b0;
         for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(posedge clk); #1;
            if (rec_done) seen = 1'b1;
         end
         chk("ov_rec_done_seen", int'(seen), 1);
      end
      count_m++;
      chk("ov_rec_count", int'(rec_count), count_m % 256);
      repeat (5) @(posedge clk);
      #1;
      chk("ov_no_retrigger", int'(busy), 0);
      chk("ov_count_stable", int'(rec_count), count_m % 256);
      chk("ov_sticky", int'(overflow), 1);
      clr_ovf = 1'b1;
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      chk("ov_cleared", int'(overflow), 0);
      finished = 1'b0;

      // reset asserted while the remainder word is pending
      push_rec(rv);
      @(posedge clk); #1;
      drive_rec(rv); finished = 1'b1; wr_ack = 1'b1;
      @(posedge clk); #1;
      finished = 1'b0;
      @(posedge clk); #1;
      wr_ack = 1'b0;
      chk("rs_in_wr1", int'(wr_data), 22);
      @(posedge clk); #1;
      #2;
      rst = 1'b0;
      #1;
      chk("rs_wr_en", int'(wr_en), 0);
      chk("rs_wr_addr", int'(wr_addr), BASE);
      chk("rs_busy", int'(busy), 0);
      chk("rs_rec_count", int'(rec_count), 0);
      chk("rs_rec_done", int'(rec_done), 0);
      exp_q.delete();
      ptr_m = 0;
      count_m = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      wr_ack = 1'b1;
      run_rec(tbl[5]);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
